// File: rtl/glb_dma_pkg.sv
// glb_dma_pkg: shared FSM encodings and address stride for the GLB DMA bridge.
package glb_dma_pkg;

    localparam logic [1:0] RD_IDLE  = 2'd0;
    localparam logic [1:0] RD_FETCH = 2'd1;
    localparam logic [1:0] RD_DRAIN = 2'd2;

    localparam logic [1:0] WR_IDLE   = 2'd0;
    localparam logic [1:0] WR_ACCEPT = 2'd1;
    localparam logic [1:0] WR_RMW    = 2'd2;

    localparam int ADDR_STRIDE = 4;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two depth FIFO with occupancy count; storage is not reset, only pointers/count.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             push_en, pop_en;

    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign dout    = mem_q[rptr_q];
    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= push_en ? wptr_q + AW'(1) : wptr_q;
            rptr_q  <= pop_en ? rptr_q + AW'(1) : rptr_q;
            count_q <= count_q + CW'(push_en) - CW'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/glb_dma_bridge.sv
// glb_dma_bridge: moves words between global-buffer BRAMs and the NoC; a prefetching read
// channel with a small FIFO and an independent write channel with optional accumulate (RMW).
module glb_dma_bridge import glb_dma_pkg::*; #(
    parameter int ADDRESS_BITWIDTH = 32,
    parameter int DATA_BITWIDTH    = 32,
    parameter int NUM_DST          = 3,
    parameter int FIFO_DEPTH       = 4,
    parameter int LEN_BITWIDTH     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_start,
    input  logic [$clog2(NUM_DST)-1:0]  rd_dst,
    input  logic [ADDRESS_BITWIDTH-1:0] rd_base,
    input  logic [LEN_BITWIDTH-1:0]     rd_len,
    output logic                        rd_busy,
    output logic                        rd_done,
    output logic [ADDRESS_BITWIDTH-1:0] IARG_address,
    output logic                        IARG_e,
    output logic [3:0]                  IARG_we,
    output logic [DATA_BITWIDTH-1:0]    IARG_wdata,
    input  logic [DATA_BITWIDTH-1:0]    IARG_rdata,
    output logic [NUM_DST-1:0]          dst_enable,
    input  logic [NUM_DST-1:0]          dst_ready,
    output logic [DATA_BITWIDTH-1:0]    dst_value,
    input  logic                        wr_start,
    input  logic                        wr_acc,
    input  logic [ADDRESS_BITWIDTH-1:0] wr_base,
    input  logic [LEN_BITWIDTH-1:0]     wr_len,
    output logic                        wr_busy,
    output logic                        wr_done,
    input  logic                        opsum_enable,
    output logic                        opsum_ready,
    input  logic [DATA_BITWIDTH-1:0]    opsum_value,
    output logic [ADDRESS_BITWIDTH-1:0] OARG_address,
    output logic                        OARG_e,
    output logic [3:0]                  OARG_we,
    output logic [DATA_BITWIDTH-1:0]    OARG_wdata,
    input  logic [DATA_BITWIDTH-1:0]    OARG_rdata
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDRESS_BITWIDTH-1:0] STRIDE = ADDRESS_BITWIDTH'(ADDR_STRIDE);
    localparam logic [LEN_BITWIDTH-1:0]     ONE    = LEN_BITWIDTH'(1);

    logic [1:0]                  rd_state_q, rd_state_d;
    logic [$clog2(NUM_DST)-1:0]  dst_q, dst_d;
    logic [ADDRESS_BITWIDTH-1:0] raddr_q, raddr_d;
    logic [LEN_BITWIDTH-1:0]     rleft_q, rleft_d;
    logic                        inflight_q, issue, pop;
    logic                        fifo_full, fifo_empty;
    logic [CW-1:0]               fifo_count;
    logic [DATA_BITWIDTH-1:0]    fifo_head;

    // Returned BRAM data is pushed unconditionally; issue throttling guarantees room.
    sync_fifo #(.WIDTH(DATA_BITWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .pop   (pop),
        .din   (IARG_rdata),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign issue        = rd_state_q == RD_FETCH && rleft_q != '0 && !fifo_full
                          && fifo_count + CW'(inflight_q) < CW'(FIFO_DEPTH);
    assign rd_done      = rd_state_q != RD_IDLE && rleft_q == '0 && !inflight_q && fifo_empty;
    assign rd_busy      = rd_state_q != RD_IDLE;
    assign dst_enable   = fifo_empty ? '0 : NUM_DST'(1) << dst_q;
    assign dst_value    = fifo_empty ? '0 : fifo_head;
    assign pop          = |(dst_enable & dst_ready);
    assign IARG_e       = issue;
    assign IARG_address = raddr_q;
    assign IARG_we      = 4'h0;
    assign IARG_wdata   = '0;

    always_comb begin
        rd_state_d = rd_state_q;
        dst_d      = dst_q;
        raddr_d    = raddr_q;
        rleft_d    = rleft_q;
        if (rd_state_q == RD_IDLE) begin
            rd_state_d = rd_start ? RD_FETCH : RD_IDLE;
            dst_d      = rd_start ? rd_dst : dst_q;
            raddr_d    = rd_start ? rd_base : raddr_q;
            rleft_d    = rd_start ? rd_len : rleft_q;
        end else if (rd_done) begin
            rd_state_d = RD_IDLE;
        end else if (issue) begin
            raddr_d    = raddr_q + STRIDE;
            rleft_d    = rleft_q - ONE;
            rd_state_d = rleft_q == ONE ? RD_DRAIN : RD_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            dst_q      <= '0;
            raddr_q    <= '0;
            rleft_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            dst_q      <= dst_d;
            raddr_q    <= raddr_d;
            rleft_q    <= rleft_d;
            inflight_q <= issue;
        end
    end

    logic [1:0]                  wr_state_q, wr_state_d;
    logic                        acc_q, acc_d, wdone_q, wdone_d;
    logic [ADDRESS_BITWIDTH-1:0] waddr_q, waddr_d;
    logic [LEN_BITWIDTH-1:0]     wleft_q, wleft_d;
    logic [DATA_BITWIDTH-1:0]    val_q, val_d;
    logic                        accept, rmw, hs, commit;

    assign accept       = wr_state_q == WR_ACCEPT;
    assign rmw          = wr_state_q == WR_RMW;
    assign opsum_ready  = accept && wleft_q != '0;
    assign hs           = opsum_ready && opsum_enable;
    assign commit       = (hs && !acc_q) || rmw;
    assign OARG_e       = hs || rmw;
    assign OARG_we      = commit ? 4'hF : 4'h0;
    assign OARG_wdata   = rmw ? val_q + OARG_rdata : commit ? opsum_value : '0;
    assign OARG_address = waddr_q;
    assign wr_done      = wdone_q || (accept && wleft_q == '0);
    assign wr_busy      = wr_state_q != WR_IDLE;

    always_comb begin
        wr_state_d = wr_state_q;
        acc_d      = acc_q;
        waddr_d    = waddr_q;
        wleft_d    = wleft_q;
        val_d      = val_q;
        wdone_d    = 1'b0;
        if (wr_state_q == WR_IDLE) begin
            wr_state_d = wr_start ? WR_ACCEPT : WR_IDLE;
            acc_d      = wr_start ? wr_acc : acc_q;
            waddr_d    = wr_start ? wr_base : waddr_q;
            wleft_d    = wr_start ? wr_len : wleft_q;
        end else if (accept && wleft_q == '0) begin
            wr_state_d = WR_IDLE;
        end else if (hs && acc_q) begin
            val_d      = opsum_value;
            wr_state_d = WR_RMW;
        end else if (commit) begin
            waddr_d    = waddr_q + STRIDE;
            wleft_d    = wleft_q - ONE;
            wr_state_d = wleft_q == ONE ? WR_IDLE : WR_ACCEPT;
            wdone_d    = wleft_q == ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= WR_IDLE;
            acc_q      <= 1'b0;
            waddr_q    <= '0;
            wleft_q    <= '0;
            val_q      <= '0;
            wdone_q    <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            acc_q      <= acc_d;
            waddr_q    <= waddr_d;
            wleft_q    <= wleft_d;
            val_q      <= val_d;
            wdone_q    <= wdone_d;
        end
    end

endmodule

// File: doc/glb_dma_bridge.md
GLB_DMA_BRIDGE -- requirements
Module: glb_dma_bridge

Interface
REQ-001 SHALL have parameter ADDRESS_BITWIDTH, default 32, BRAM byte-address width.
REQ-002 SHALL have parameter DATA_BITWIDTH, default 32, BRAM word and NoC value width.
REQ-003 SHALL have parameter NUM_DST, default 3, read destinations (0 ifmap, 1 filter, 2 ipsum).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, power of two ≥2, read-side buffer depth.
REQ-005 SHALL have parameter LEN_BITWIDTH, default 16, transfer-length counter width.
REQ-006 SHALL have ports clk input 1, single clock; rst input 1, reset is asynchronous and active-high.
REQ-007 SHALL have ports rd_start in 1; rd_dst in clog2(NUM_DST); rd_base in ADDRESS_BITWIDTH; rd_len in LEN_BITWIDTH words; rd_busy out 1; rd_done out 1 pulse.
REQ-008 SHALL have ports IARG_address out ADDRESS_BITWIDTH; IARG_e out 1; IARG_we out 4, tied 0; IARG_wdata out DATA_BITWIDTH, tied 0; IARG_rdata in DATA_BITWIDTH.
REQ-009 SHALL have ports dst_enable out NUM_DST, valid per destination; dst_ready in NUM_DST; dst_value out DATA_BITWIDTH, shared.
REQ-010 SHALL have ports wr_start in 1; wr_acc in 1, accumulate mode; wr_base in ADDRESS_BITWIDTH; wr_len in LEN_BITWIDTH; wr_busy out 1; wr_done out 1 pulse.
REQ-011 SHALL have ports opsum_enable in 1, valid; opsum_ready out 1; opsum_value in DATA_BITWIDTH.
REQ-012 SHALL have ports OARG_address out; OARG_e out; OARG_we out 4; OARG_wdata out; OARG_rdata in (widths as IARG).

Function
REQ-013 BRAM SHALL be treated as 1-cycle read latency; word i address = base + 4*i, modulo 2^ADDRESS_BITWIDTH.
REQ-014 Read FSM SHALL have states RD_IDLE, RD_FETCH, RD_DRAIN; rd_start in RD_IDLE latches rd_dst/rd_base/rd_len, enters RD_FETCH; rd_start otherwise ignored.
REQ-015 In RD_FETCH a read SHALL be issued (IARG_e=1) only when fifo_count + inflight < FIFO_DEPTH; after rd_len issues go RD_DRAIN.
REQ-016 Returned IARG_rdata SHALL be pushed into the FIFO the cycle after issue; no word lost or reordered under any dst_ready pattern.
REQ-017 dst_enable[latched dst] SHALL equal FIFO non-empty, other bits 0; dst_value = FIFO head; pop on enable&ready.
REQ-018 rd_done SHALL pulse one cycle when all words issued, none inflight, FIFO empty; FSM returns to RD_IDLE the same cycle.
REQ-019 rd_len=0 SHALL produce rd_done the cycle after rd_start with no IARG_e.
REQ-020 Write FSM SHALL have states WR_IDLE, WR_ACCEPT, WR_RMW; wr_start in WR_IDLE latches wr_acc/wr_base/wr_len, enters WR_ACCEPT (rd_len=0 rule of REQ-019 applies to wr_len).
REQ-021 Plain mode: opsum_ready=1 in WR_ACCEPT; each handshake SHALL drive OARG_e=1, OARG_we=4'hF, OARG_wdata=opsum_value same cycle (zero latency, one word/cycle).
REQ-022 Acc mode: handshake SHALL issue read (OARG_e=1, we=0) and go WR_RMW with opsum_ready=0; WR_RMW SHALL write latched value + OARG_rdata, truncated to DATA_BITWIDTH, we=4'hF, then return to WR_ACCEPT.
REQ-023 wr_done SHALL pulse the cycle after the last BRAM write; FSM then in WR_IDLE.
REQ-024 Read and write paths SHALL operate independently and concurrently.
REQ-025 rd_busy/wr_busy SHALL be 1 exactly when respective FSM is not idle.

Reset
REQ-026 rst SHALL asynchronously force both FSMs idle, clear FIFO, counters, inflight flag.
REQ-027 During reset all outputs SHALL be 0, including mid-transfer; in-flight read data SHALL be discarded.

Structure
REQ-028 State encodings and ADDR_STRIDE=4 SHALL reside in shared package glb_dma_pkg.
REQ-029 Read buffer SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-030 rd_dst=1, base=0x100, len=6, dst_ready=1 -> IARG_address 0x100..0x114, six values in order on dst_enable[1], rd_done once.
REQ-031 Same read with dst_ready low 10 cycles -> at most FIFO_DEPTH issues before stall, no loss, resumes in order.
REQ-032 Plain write base=0x40, len=3, values 1,2,3 -> writes 0x40/0x44/0x48 data 1/2/3, wr_done cycle after third.
REQ-033 Acc write len=2, mem 10,0xFFFFFFFF, opsum 5,1 -> mem 15,0x00000000, opsum_ready low every RMW cycle.
REQ-034 rd_len=0 and wr_len=0 starts -> done pulses next cycle, no BRAM enables.
REQ-035 rst asserted mid-read after 3 of 8 words -> outputs 0 immediately, idle; new read after release runs correctly.
